// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill sequencer: one line request, LINE_WORDS beats assembled into a line, one fill strobe.
// Optional critical-word-first ordering and forwarding under `define CRITICAL_WORD_FIRST_EN.
module icache_refill_ctrl #(
  parameter int XLEN       = 16,
  parameter int ILEN       = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         miss_i,
  input  logic [XLEN-1:0]              miss_addr_i,
  input  logic                         flush_i,
  output logic                         busy_o,
  output logic                         mem_req_valid_o,
  input  logic                         mem_req_ready_i,
  output logic [XLEN-1:0]              mem_req_addr_o,
  input  logic                         mem_rsp_valid_i,
  input  logic [ILEN-1:0]              mem_rsp_data_i,
  output logic                         fill_valid_o,
  output logic [XLEN-1:0]              fill_pc_o,
  output logic [LINE_WORDS*ILEN-1:0]   fill_line_o,
  output logic                         crit_valid_o,
  output logic [ILEN-1:0]              crit_data_o
);

  localparam int WOFF     = $clog2(ILEN / 8);
  localparam int WIDX     = $clog2(LINE_WORDS);
  localparam int LINE_LEN = LINE_WORDS * ILEN;

  localparam logic [XLEN-1:0] LINE_MASK = ~((XLEN'(1) << (WOFF + WIDX)) - XLEN'(1));
`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [XLEN-1:0] WORD_MASK = ~((XLEN'(1) << WOFF) - XLEN'(1));
`endif
  localparam logic [WIDX:0]   LAST_CNT  = (WIDX + 1)'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_FILL,
    S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       line_addr_q, line_addr_d;
  logic [XLEN-1:0]       req_addr_q, req_addr_d;
  logic [WIDX-1:0]       start_q, start_d;
  logic [WIDX:0]         cnt_q, cnt_d;
  logic [LINE_LEN-1:0]   buf_q, buf_d;
  logic                  fill_valid_q, fill_valid_d;
  logic [XLEN-1:0]       fill_pc_q, fill_pc_d;
  logic [LINE_LEN-1:0]   fill_line_q, fill_line_d;
`ifdef CRITICAL_WORD_FIRST_EN
  logic                  crit_valid_q, crit_valid_d;
  logic [ILEN-1:0]       crit_data_q, crit_data_d;
`endif

  logic [WIDX-1:0]       widx;
  logic [WIDX:0]         cnt_inc;
  logic                  last_beat;

  always_comb begin
    widx      = start_q + cnt_q[WIDX-1:0];
    cnt_inc   = cnt_q + (WIDX + 1)'(1);
    last_beat = mem_rsp_valid_i && (cnt_q == LAST_CNT);
  end

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    req_addr_d   = req_addr_q;
    start_d      = start_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    fill_valid_d = 1'b0;
    fill_pc_d    = fill_pc_q;
    fill_line_d  = fill_line_q;
`ifdef CRITICAL_WORD_FIRST_EN
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (miss_i) begin
          line_addr_d = miss_addr_i & LINE_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
          req_addr_d  = miss_addr_i & WORD_MASK;
          start_d     = miss_addr_i[WOFF +: WIDX];
`else
          req_addr_d  = miss_addr_i & LINE_MASK;
          start_d     = '0;
`endif
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = flush_i ? S_DRAIN : S_RECV;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end

      S_RECV: begin
        if (mem_rsp_valid_i) begin
          for (int unsigned k = 0; k < LINE_WORDS; k++) begin
            if (widx == WIDX'(k)) buf_d[k*ILEN +: ILEN] = mem_rsp_data_i;
          end
          cnt_d = cnt_inc;
`ifdef CRITICAL_WORD_FIRST_EN
          if ((cnt_q == '0) && !flush_i) begin
            crit_valid_d = 1'b1;
            crit_data_d  = mem_rsp_data_i;
          end
`endif
        end
        // A flush that coincides with the final beat has nothing left to drain.
        if (flush_i) begin
          state_d = last_beat ? S_IDLE : S_DRAIN;
        end else if (last_beat) begin
          state_d      = S_FILL;
          fill_valid_d = 1'b1;
          fill_pc_d    = line_addr_q;
          fill_line_d  = buf_d;
        end
      end

      S_FILL: begin
        state_d = S_IDLE;
      end

      S_DRAIN: begin
        if (mem_rsp_valid_i) begin
          cnt_d = cnt_inc;
          if (last_beat) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      line_addr_q  <= '0;
      req_addr_q   <= '0;
      start_q      <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
      fill_valid_q <= 1'b0;
      fill_pc_q    <= '0;
      fill_line_q  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      req_addr_q   <= req_addr_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      fill_valid_q <= fill_valid_d;
      fill_pc_q    <= fill_pc_d;
      fill_line_q  <= fill_line_d;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
`endif
    end
  end

  assign busy_o          = (state_q != S_IDLE);
  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_addr_o  = req_addr_q;
  // Fill strobe is registered, but a flush arriving in the FILL cycle itself still has to kill it.
  assign fill_valid_o    = fill_valid_q & ~flush_i;
  assign fill_pc_o       = fill_pc_q;
  assign fill_line_o     = fill_line_q;
`ifdef CRITICAL_WORD_FIRST_EN
  assign crit_valid_o    = crit_valid_q;
  assign crit_data_o     = crit_data_q;
`else
  assign crit_valid_o    = 1'b0;
  assign crit_data_o     = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl (XLEN=16, ILEN=8, LINE_WORDS=4);
// follows CRITICAL_WORD_FIRST_EN so the same bench covers both builds.
module tb_icache_refill_ctrl;

  localparam int XLEN = 16;
  localparam int ILEN = 8;
  localparam int LW   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              miss;
  logic [XLEN-1:0]   miss_addr;
  logic              flush;
  logic              busy;
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              rsp_valid;
  logic [ILEN-1:0]   rsp_data;
  logic              fill_valid;
  logic [XLEN-1:0]   fill_pc;
  logic [LW*ILEN-1:0] fill_line;
  logic              crit_valid;
  logic [ILEN-1:0]   crit_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(.XLEN(XLEN), .ILEN(ILEN), .LINE_WORDS(LW)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .miss_i          (miss),
    .miss_addr_i     (miss_addr),
    .flush_i         (flush),
    .busy_o          (busy),
    .mem_req_valid_o (req_valid),
    .mem_req_ready_i (req_ready),
    .mem_req_addr_o  (req_addr),
    .mem_rsp_valid_i (rsp_valid),
    .mem_rsp_data_i  (rsp_data),
    .fill_valid_o    (fill_valid),
    .fill_pc_o       (fill_pc),
    .fill_line_o     (fill_line),
    .crit_valid_o    (crit_valid),
    .crit_data_o     (crit_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [ILEN-1:0] d);
    rsp_valid = 1'b1;
    rsp_data  = d;
    step;
    rsp_valid = 1'b0;
    rsp_data  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy,       1'b0);
    check({tag, "_rqv"},   req_valid,  1'b0);
    check({tag, "_rqa"},   req_addr,   16'h0);
    check({tag, "_fv"},    fill_valid, 1'b0);
    check({tag, "_fpc"},   fill_pc,    16'h0);
    check({tag, "_fline"}, fill_line,  32'h0);
    check({tag, "_cv"},    crit_valid, 1'b0);
    check({tag, "_cd"},    crit_data,  8'h0);
  endtask

  // Full refill: miss at cycle 0, ready at cycle 1, beats from cycle 2 with `gap` idle cycles between.
  task automatic run_refill(input string tag, input logic [XLEN-1:0] addr, input int gap,
                            input logic [31:0] line, input logic [XLEN-1:0] exp_pc,
                            input bit flush_in_fill);
    logic [1:0]      s;
    logic [1:0]      w;
    logic [XLEN-1:0] exp_req;
`ifdef CRITICAL_WORD_FIRST_EN
    s       = addr[1:0];
    exp_req = addr;
`else
    s       = 2'd0;
    exp_req = exp_pc;
`endif
    miss      = 1'b1;
    miss_addr = addr;
    step;
    miss = 1'b0;
    check({tag, "_req_v"}, req_valid, 1'b1);
    check({tag, "_req_a"}, req_addr,  exp_req);
    check({tag, "_busy1"}, busy,      1'b1);
    req_ready = 1'b1;
    step;
    req_ready = 1'b0;
    check({tag, "_req_drop"}, req_valid, 1'b0);
    for (int c = 0; c < LW; c++) begin
      w = s + 2'(c);
      beat(line[w*8 +: 8]);
      if (c == 0) begin
`ifdef CRITICAL_WORD_FIRST_EN
        check({tag, "_crit_v"}, crit_valid, 1'b1);
        check({tag, "_crit_d"}, crit_data,  line[s*8 +: 8]);
`else
        check({tag, "_crit_v"}, crit_valid, 1'b0);
`endif
      end
      if (c < LW - 1) begin
        check({tag, "_early_fill"}, fill_valid, 1'b0);
        repeat (gap) begin
          step;
          check({tag, "_gap_fill"}, fill_valid, 1'b0);
          check({tag, "_gap_busy"}, busy,       1'b1);
        end
      end
    end
    if (flush_in_fill) begin
      flush = 1'b1;
      #1;
      check({tag, "_fill_v_kill"}, fill_valid, 1'b0);
    end else begin
      check({tag, "_fill_v"},    fill_valid, 1'b1);
      check({tag, "_fill_pc"},   fill_pc,    exp_pc);
      check({tag, "_fill_line"}, fill_line,  line);
    end
    check({tag, "_busy_fill"}, busy, 1'b1);
    step;
    flush = 1'b0;
    check({tag, "_busy_end"}, busy,       1'b0);
    check({tag, "_fv_end"},   fill_valid, 1'b0);
    if (!flush_in_fill) check({tag, "_hold_line"}, fill_line, line);
  endtask

  initial begin
    rst_n     = 1'b0;
    miss      = 1'b0;
    miss_addr = '0;
    flush     = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    step;
    step;
    check_all_zero("reset");
    rst_n = 1'b1;
    step;

    // Basic / critical-word-first refill of 0x0036.
    run_refill("basic", 16'h0036, 0, 32'hD3C2B1A0, 16'h0034, 1'b0);

    // Flush during request backpressure: no handshake, no fill.
    miss      = 1'b1;
    miss_addr = 16'h0036;
    step;
    miss = 1'b0;
    step;
    check("bp_req_v",  req_valid, 1'b1);
    flush = 1'b1;
    step;
    flush = 1'b0;
    check("bp_idle",   busy,       1'b0);
    check("bp_req_off", req_valid, 1'b0);
    step;
    check("bp_no_fill", fill_valid, 1'b0);
    check("bp_hold_line", fill_line, 32'hD3C2B1A0);

    // Flush mid-RECV after two beats, drain the last two.
    miss      = 1'b1;
    miss_addr = 16'h0036;
    step;
    miss      = 1'b0;
    req_ready = 1'b1;
    step;
    req_ready = 1'b0;
    beat(8'h11);
    beat(8'h22);
    flush = 1'b1;
    step;
    flush = 1'b0;
    check("mid_drain_busy", busy, 1'b1);
    beat(8'h33);
    check("mid_drain_busy2", busy,       1'b1);
    check("mid_drain_nofv",  fill_valid, 1'b0);
    beat(8'h44);
    check("mid_drain_done",  busy,       1'b0);
    check("mid_drain_nofv2", fill_valid, 1'b0);
    run_refill("after_flush", 16'h0040, 0, 32'h44332211, 16'h0040, 1'b0);

    // Flush in the handshake cycle: request issued, all four beats drained.
    miss      = 1'b1;
    miss_addr = 16'h0100;
    step;
    miss      = 1'b0;
    req_ready = 1'b1;
    flush     = 1'b1;
    step;
    req_ready = 1'b0;
    flush     = 1'b0;
    check("hs_flush_drain", busy, 1'b1);
    beat(8'h01);
    beat(8'h02);
    beat(8'h03);
    check("hs_flush_busy", busy, 1'b1);
    beat(8'h04);
    check("hs_flush_done", busy,       1'b0);
    check("hs_flush_nofv", fill_valid, 1'b0);
    check("hs_flush_pc",   fill_pc,    16'h0040);

    // Gapped beats, different start word.
    run_refill("gap", 16'h1237, 2, 32'h0F1E2D3C, 16'h1234, 1'b0);

    // Flush in the FILL cycle kills the strobe.
    run_refill("fillkill", 16'h0208, 0, 32'h55667788, 16'h0208, 1'b1);

    // Reset mid-RECV.
    miss      = 1'b1;
    miss_addr = 16'h0036;
    step;
    miss      = 1'b0;
    req_ready = 1'b1;
    step;
    req_ready = 1'b0;
    beat(8'h9A);
    beat(8'h9B);
    rst_n = 1'b0;
    step;
    check_all_zero("midrst");
    rst_n = 1'b1;
    step;
    run_refill("post_rst", 16'h0036, 0, 32'hD3C2B1A0, 16'h0034, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
